// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory-port arbiter.
// Requester IDs double as bit positions in the arbiter's request vector.
package cpu_mem_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } mem_arb_state_t;

   typedef logic req_id_t;

   localparam req_id_t REQ_IF = 1'b0;
   localparam req_id_t REQ_D  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, and on a tie
// the requester that was not served last wins.
module rr_arb2
   import cpu_mem_pkg::*;
(
   input  logic [1:0] i_req,
   input  req_id_t    i_lastServed,
   output logic       o_anyReq,
   output req_id_t    o_winner
);

   // Purely combinational; the top registers the result on the IDLE->ISSUE edge.
   always_comb begin
      o_anyReq = |i_req;
      o_winner = REQ_IF;
      unique case (i_req)
         2'b01:   o_winner = REQ_IF;
         2'b10:   o_winner = REQ_D;
         2'b11:   o_winner = (i_lastServed == REQ_D) ? REQ_IF : REQ_D;
         default: o_winner = REQ_IF;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and
// load/store, one access per three cycles, with fully registered outputs.
module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W = cpu_mem_pkg::ADDR_W,
   parameter int DATA_W = cpu_mem_pkg::DATA_W
)
(
   input  logic              clk,
   input  logic              rst,

   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,

   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,

   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   mem_arb_state_t r_state;
   req_id_t        r_lastServed;
   req_id_t        r_winner;
   logic           r_isWrite;

   logic [1:0]     w_reqVec;
   logic           w_anyReq;
   req_id_t        w_winner;

   assign w_reqVec[REQ_IF] = if_req;
   assign w_reqVec[REQ_D]  = d_req;

   rr_arb2 u_rrArb (
      .i_req        (w_reqVec),
      .i_lastServed (r_lastServed),
      .o_anyReq     (w_anyReq),
      .o_winner     (w_winner)
   );

   // Outputs are assigned on the edge that enters the state they belong to,
   // so gnt/mem_en appear in ISSUE and valid appears in the following IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_lastServed <= REQ_D;
         r_winner     <= REQ_IF;
         r_isWrite    <= 1'b0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         if_gnt       <= 1'b0;
         d_gnt        <= 1'b0;
         if_valid     <= 1'b0;
         d_valid      <= 1'b0;
         if_rdata     <= '0;
         d_rdata      <= '0;
      end else begin
         if_gnt   <= 1'b0;
         d_gnt    <= 1'b0;
         if_valid <= 1'b0;
         d_valid  <= 1'b0;

         unique case (r_state)
            IDLE: begin
               if (w_anyReq) begin
                  r_state      <= ISSUE;
                  r_winner     <= w_winner;
                  r_lastServed <= w_winner;
                  mem_en       <= 1'b1;
                  if (w_winner == REQ_IF) begin
                     mem_addr  <= if_addr;
                     mem_we    <= 1'b0;
                     mem_wdata <= '0;
                     r_isWrite <= 1'b0;
                     if_gnt    <= 1'b1;
                  end else begin
                     mem_addr  <= d_addr;
                     mem_we    <= d_we;
                     mem_wdata <= d_wdata;
                     r_isWrite <= d_we;
                     d_gnt     <= 1'b1;
                  end
               end
            end

            ISSUE: begin
               mem_en  <= 1'b0;
               mem_we  <= 1'b0;
               r_state <= RESP;
            end

            // Memory read data is valid here, one cycle after mem_en.
            RESP: begin
               if (r_winner == REQ_IF) begin
                  if_rdata <= mem_rdata;
                  if_valid <= 1'b1;
               end else begin
                  if (!r_isWrite) begin
                     d_rdata <= mem_rdata;
                  end
                  d_valid <= 1'b1;
               end
               r_state <= IDLE;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory and a
// scoreboard queue of expected responses.
module tb_mem_port_arbiter;
   import cpu_mem_pkg::*;

   localparam int AW = 16;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_gnt, if_valid;
   logic [DW-1:0] if_rdata;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          d_gnt, d_valid;
   logic [DW-1:0] d_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_valid  (if_valid),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_valid   (d_valid),
      .d_rdata   (d_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous memory array plus an independent reference copy of its contents.
   logic [DW-1:0] memArr [0:255];
   logic [DW-1:0] refMem [0:255];
   int            memEnCount = 0;

   always @(posedge clk) begin
      if (mem_en) begin
         memEnCount <= memEnCount + 1;
         if (mem_we) memArr[mem_addr[7:0]] <= mem_wdata;
         else        mem_rdata <= memArr[mem_addr[7:0]];
      end
   end

   typedef struct {
      logic          isFetch;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sbq[$];
   logic [DW-1:0] ifModel = '0;
   logic [DW-1:0] dModel = '0;
   int            expAccesses = 0;
   int            total = 0;
   int            bad = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
         $error("[TB] %s differs", tag);
      end
   endtask

   task automatic pushExp(input logic isFetch, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      exp_t e;
      e.isFetch = isFetch;
      if (isFetch) begin
         e.data  = refMem[addr[7:0]];
         ifModel = e.data;
      end else if (we) begin
         refMem[addr[7:0]] = wdata;
         e.data = dModel;
      end else begin
         e.data = refMem[addr[7:0]];
         dModel = e.data;
      end
      sbq.push_back(e);
      expAccesses++;
   endtask

   task automatic applyStimulus(input logic isFetch, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      if (isFetch) begin
         if_req  = 1'b1;
         if_addr = addr;
      end else begin
         d_req   = 1'b1;
         d_we    = we;
         d_addr  = addr;
         d_wdata = wdata;
      end
      pushExp(isFetch, we, addr, wdata);
   endtask

   task automatic popCheck(input string tag);
      exp_t e;
      checkOutput({tag, "_sbNonEmpty"}, 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() == 0) return;
      e = sbq.pop_front();
      checkOutput({tag, "_ifValid"}, 32'(if_valid), 32'(e.isFetch));
      checkOutput({tag, "_dValid"}, 32'(d_valid), 32'(!e.isFetch));
      if (e.isFetch) checkOutput({tag, "_ifRdata"}, 32'(if_rdata), 32'(e.data));
      else           checkOutput({tag, "_dRdata"}, 32'(d_rdata), 32'(e.data));
   endtask

   // Expects the request already driven and the FSM in IDLE; returns at the
   // falling edge of the valid cycle, which is again an IDLE cycle.
   task automatic runAccess(input string tag, input logic isFetch, input logic isWrite,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input logic dropReq);
      @(posedge clk); @(negedge clk);
      checkOutput({tag, "_gnt"}, 32'(isFetch ? if_gnt : d_gnt), 32'd1);
      checkOutput({tag, "_otherGnt"}, 32'(isFetch ? d_gnt : if_gnt), 32'd0);
      checkOutput({tag, "_memEn"}, 32'(mem_en), 32'd1);
      checkOutput({tag, "_memAddr"}, 32'(mem_addr), 32'(addr));
      checkOutput({tag, "_memWe"}, 32'(mem_we), 32'(isWrite));
      if (isWrite) checkOutput({tag, "_memWdata"}, 32'(mem_wdata), 32'(wdata));
      if (dropReq) begin
         if (isFetch) if_req = 1'b0;
         else         d_req  = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      checkOutput({tag, "_respMemEn"}, 32'(mem_en), 32'd0);
      checkOutput({tag, "_respGnt"}, 32'(if_gnt | d_gnt), 32'd0);
      @(posedge clk); @(negedge clk);
      popCheck(tag);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ctl"}, 32'({mem_en, mem_we, if_gnt, d_gnt, if_valid, d_valid}), 32'd0);
      checkOutput({tag, "_memAddr"}, 32'(mem_addr), 32'd0);
      checkOutput({tag, "_memWdata"}, 32'(mem_wdata), 32'd0);
      checkOutput({tag, "_ifRdata"}, 32'(if_rdata), 32'd0);
      checkOutput({tag, "_dRdata"}, 32'(d_rdata), 32'd0);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;
      ifModel = '0;
      dModel  = '0;
      sbq.delete();
      @(negedge clk);
   endtask

   initial begin
      logic sticky;
      for (int i = 0; i < 256; i++) begin
         memArr[i] = DW'(i * 3 + 1);
         refMem[i] = DW'(i * 3 + 1);
      end
      memArr[8'h10] = 16'hABCD;
      refMem[8'h10] = 16'hABCD;

      doReset();

      // Single fetch; the data side must stay quiet.
      applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
      runAccess("fetch1", 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
      checkOutput("fetch1_dRdataQuiet", 32'(d_rdata), 32'(dModel));
      @(negedge clk);

      // Store, then load back; the store leaves d_rdata alone.
      applyStimulus(1'b0, 1'b1, 16'h0020, 16'h1234);
      runAccess("store20", 1'b0, 1'b1, 16'h0020, 16'h1234, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 16'h0020, 16'h0000);
      runAccess("load20", 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b1);
      checkOutput("load20_ifRdataHeld", 32'(if_rdata), 32'(ifModel));

      // Back-to-back: each new request is raised in the valid cycle of the previous one.
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 16'h0010, 16'h0000);
      runAccess("b2b_load", 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1);
      applyStimulus(1'b0, 1'b1, 16'h0040, 16'h5A5A);
      runAccess("b2b_store", 1'b0, 1'b1, 16'h0040, 16'h5A5A, 1'b1);
      applyStimulus(1'b0, 1'b0, 16'h0040, 16'h0000);
      runAccess("b2b_reload", 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1);

      // Both requesters held high after reset: fetch first, then strict alternation.
      doReset();
      if_req = 1'b1; if_addr = 16'h0010;
      d_req  = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
      for (int k = 0; k < 4; k++) pushExp((k % 2) == 0, 1'b0, ((k % 2) == 0) ? 16'h0010 : 16'h0020, 16'h0000);
      for (int k = 0; k < 4; k++) begin
         runAccess($sformatf("tie%0d", k), (k % 2) == 0, 1'b0,
                   ((k % 2) == 0) ? 16'h0010 : 16'h0020, 16'h0000, k >= 2);
      end
      @(negedge clk);

      // Reset pulsed in ISSUE: outputs clear at once and the access never responds.
      if_req = 1'b1; if_addr = 16'h0030;
      @(posedge clk); @(negedge clk);
      checkOutput("midRst_issueGnt", 32'(if_gnt), 32'd1);
      if_req = 1'b0;
      #1 rst = 1'b1;
      #1 checkAllZero("midRst");
      @(negedge clk);
      rst = 1'b0;
      ifModel = '0;
      dModel  = '0;
      sticky = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         sticky = sticky | if_valid | d_valid | if_gnt | d_gnt | mem_en;
      end
      checkOutput("midRst_noResponse", 32'(sticky), 32'd0);

      // After that reset, a tie again goes to fetch first.
      if_req = 1'b1; if_addr = 16'h0010;
      d_req  = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
      pushExp(1'b1, 1'b0, 16'h0010, 16'h0000);
      pushExp(1'b0, 1'b0, 16'h0040, 16'h0000);
      runAccess("postRst_fetch", 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
      runAccess("postRst_data", 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1);
      @(negedge clk);

      // A request high only between clock edges is never seen.
      if_req = 1'b1;
      #2 if_req = 1'b0;
      sticky = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         sticky = sticky | mem_en | if_gnt | if_valid;
      end
      checkOutput("withdrawn_noAccess", 32'(sticky), 32'd0);

      checkOutput("memEnCount", 32'(memEnCount), 32'(expAccesses));
      checkOutput("sbDrained", 32'(sbq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single-port synchronous data/instruction memory between the instruction-fetch unit and the load/store unit. Sits between the fetch and memory stages of the CPU core and the memory array. It arbitrates round-robin on conflict and sequences each access through a fixed three-state FSM. It returns read data or a write acknowledge to the winning requester.

## Interface

**Parameters**
- ADDR_W, 16, memory word-address width
- DATA_W, 16, memory word width

**Ports**
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; level, held until if_gnt
- if_addr  in  ADDR_W  fetch address; stable while if_req high
- if_gnt  out  1  one-cycle pulse: fetch access issued to memory
- if_valid  out  1  one-cycle pulse: if_rdata holds fetched word
- if_rdata  out  DATA_W  fetched word
- d_req  in  1  load/store request; level, held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  load/store address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle pulse: data access issued
- d_valid  out  1  one-cycle pulse: load data ready, or store complete
- d_rdata  out  DATA_W  load data; updated on loads only
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable; only meaningful with mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en

## Operation

**FSM states:** IDLE, ISSUE, RESP.

**IDLE**
- Sample if_req and d_req.
- If neither is set, stay in IDLE.
- Otherwise pick a winner and move to ISSUE. On the same edge, latch the winner's address, we and wdata; fetch always has we = 0.

**Arbitration**
- Single requester: that requester wins.
- Both requesters: the one not served last wins.
- last_served register is updated on every IDLE→ISSUE transition.

**ISSUE**
- mem_en = 1; mem_we, mem_addr and mem_wdata come from the latched values.
- Winner's gnt = 1. Go to RESP.

**RESP**
- mem_en = 0.
- On a read, capture mem_rdata into the winner's rdata register.
- Set the winner's valid for the next cycle. Go to IDLE.

**Request handling**
- Requests are ignored in ISSUE and RESP.
- A requester drops req in the cycle after it sees gnt.
- A req still high when the FSM is back in IDLE counts as a new request.
- A req dropped before IDLE samples it produces no access and no response.

**Rdata registers**
- if_rdata and d_rdata hold their value until the next read for that requester.
- A store leaves d_rdata unchanged.

## Timing

**Reset values** (asynchronous; rst applies them immediately, at any time):
- State = IDLE; last_served = data, so fetch wins the first tie.
- All outputs = 0: mem_en, mem_we, mem_addr, mem_wdata, if_gnt, d_gnt, if_valid, d_valid, if_rdata, d_rdata.

**Request sampled at edge N (IDLE):**
- Cycle N+1 (ISSUE): mem_en = 1 and gnt = 1.
- Cycle N+2 (RESP): mem_rdata is valid.
- Cycle N+3: valid = 1 and rdata is valid.

**Throughput and overlap**
- Peak rate is one access per 3 cycles.
- The valid pulse in cycle N+3 coincides with IDLE, which may already sample the next request.

**Outputs**
- All outputs are registered; no combinational input→output paths.

**Reset mid-access**
- The access is abandoned and no gnt or valid is produced.
- A write already presented in ISSUE may or may not complete in memory; that is not an error.

## Structure

**Shared package cpu_mem_pkg:**
- mem_arb_state_t enum {IDLE, ISSUE, RESP}.
- Requester-ID constants REQ_IF = 0 and REQ_D = 1 (1-bit type req_id_t).
- Default widths ADDR_W = 16 and DATA_W = 16.

**Sub-module**
- One sub-module, rr_arb2: the combinational two-way round-robin pick from req[1:0] and last_served.
- Everything else stays flat in mem_port_arbiter.

## Test plan

- **Single fetch:** if_req = 1, if_addr = 0x0010, memory[0x10] = 0xABCD → mem_en at N+1 with mem_addr = 0x0010 and if_gnt pulse; if_valid at N+3 with if_rdata = 0xABCD; d_* outputs stay 0.
- **Store then load:** d_we = 1, d_addr = 0x0020, d_wdata = 0x1234 → mem_we = 1 at N+1 and d_valid at N+3 with d_rdata unchanged. Then load 0x0020 → d_rdata = 0x1234.
- **Simultaneous requests after reset:** if_req and d_req held high → fetch granted first, data second, then fetch again, alternating. Grants are 3 cycles apart and no requester waits more than 6 cycles.
- **Back-to-back:** d_req re-asserted in the cycle of d_valid → new ISSUE exactly 1 cycle later; no lost or duplicate access.
- **Reset mid-access:** rst pulsed during ISSUE → all outputs 0 immediately, no valid pulse afterwards. After release, the next request is served with normal latency and fetch wins the first tie.
- **Withdrawn request:** if_req pulsed for 0 sampled edges (high only between edges) → mem_en never asserts.
